// File: rtl/clk_gen_bank.sv
// rtl/clk_gen_bank.sv - NCH-channel programmable clock divider bank with shadowed config
module clk_gen_bank #(
    parameter int NCH   = 4,
    parameter int DIV_W = 8,
    localparam int AW   = $clog2(NCH) + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [DIV_W-1:0] cfg_wdata,
    output logic [DIV_W-1:0] cfg_rdata,
    input  logic             sync_all,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   wrap
);

    localparam logic [1:0] SEL_PERIOD = 2'd0;
    localparam logic [1:0] SEL_HIGH   = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // Channel index is everything above the two register-select bits.
    logic [AW-1:0]    ch_field;
    int               ch_idx;
    logic [1:0]       sel;
    logic [DIV_W-1:0] rd_ch [NCH];

    assign ch_field = cfg_addr >> 2;
    assign ch_idx   = int'(ch_field);
    assign sel      = cfg_addr[1:0];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] pend_period, pend_high, act_period, act_high, cnt;
        logic             pend_en, act_en;
        logic             co_q, wr_q;
        logic             wr_hit, at_end, reload, differs;
        logic [DIV_W-1:0] rd;

        assign wr_hit  = cfg_we && (ch_idx == i);
        assign at_end  = (cnt == act_period);
        // Active copy only changes at a period boundary, while stopped, or on sync.
        assign reload  = sync_all || !act_en || at_end;
        assign differs = (pend_period != act_period) || (pend_high != act_high)
                         || (pend_en != act_en);

        // Pending registers take config writes; STATUS writes fall through.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_period <= '0;
                pend_high   <= '0;
                pend_en     <= 1'b0;
            end else if (wr_hit) begin
                case (sel)
                    SEL_PERIOD: pend_period <= cfg_wdata;
                    SEL_HIGH:   pend_high   <= cfg_wdata;
                    SEL_CTRL:   pend_en     <= cfg_wdata[0];
                    default:    ;
                endcase
            end
        end

        // Shadow transfer and counter; pending sampled before any same-cycle write.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_period <= '0;
                act_high   <= '0;
                act_en     <= 1'b0;
                cnt        <= '0;
            end else if (reload) begin
                act_period <= pend_period;
                act_high   <= pend_high;
                act_en     <= pend_en;
                cnt        <= '0;
            end else begin
                cnt        <= cnt + 1'b1;
            end
        end

        // Registered outputs derived from the pre-edge counter and active config.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                co_q <= 1'b0;
                wr_q <= 1'b0;
            end else begin
                co_q <= act_en && (cnt < act_high);
                wr_q <= act_en && at_end;
            end
        end

        // Per-channel read view of the active registers plus status.
        always_comb begin
            rd = '0;
            case (sel)
                SEL_PERIOD: rd = act_period;
                SEL_HIGH:   rd = act_high;
                SEL_CTRL:   rd[0] = act_en;
                SEL_STATUS: begin
                    rd[0] = act_en;
                    rd[1] = differs;
                end
                default:    rd = '0;
            endcase
        end

        assign rd_ch[i]   = rd;
        assign clk_out[i] = co_q;
        assign wrap[i]    = wr_q;
    end

    // Read mux; an address naming a nonexistent channel returns zero.
    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_idx == i) cfg_rdata = rd_ch[i];
        end
    end

endmodule
